// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM state
// encoding, the word-alignment mask and the timeout counter width helper.
package mem_ctrl_pkg;

  typedef logic [1:0] mem_state_t;

  localparam mem_state_t IDLE = 2'd0;
  localparam mem_state_t REQ  = 2'd1;
  localparam mem_state_t RSP  = 2'd2;
  localparam mem_state_t DONE = 2'd3;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // Counter width able to hold the value TIMEOUT_CYCLES.
  function automatic int timeout_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Response-wait counter for the MEM-stage access controller.
// Only built when MEM_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = timeout_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Expires during the TIMEOUT_CYCLES-th consecutive enabled cycle.
  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count enabled cycles since the last clear, holding once expired.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_access_controller.sv
// MEM-stage sequencer: turns the EX/MEM load/store controls into a
// valid/ready bus request, waits for the response, stalls the pipeline
// while the access is outstanding and flags bad or timed-out accesses.
// Optional feature: define MEM_TIMEOUT_EN to abort responses that take
// longer than TIMEOUT_CYCLES cycles.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              fault,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata
);

  mem_state_t state;

  logic op_any;
  logic op_conflict;
  logic op_misaligned;
  logic op_ok;
  logic op_bad;
  logic timeout_hit;

  assign op_any        = mem_read | mem_write;
  assign op_conflict   = mem_read & mem_write;
  assign op_misaligned = (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  assign op_ok         = op_any && !op_conflict && !op_misaligned;
  assign op_bad        = op_any && (op_conflict || op_misaligned);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state == REQ) && bus_req_ready),
    .enable (state == RSP),
    .expired(timeout_hit)
  );
`else
  // RSP never times out in this build; the comparison is always false for
  // any legal parameter value and keeps the parameter referenced.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Request valid follows the state directly so an asynchronous reset
  // withdraws it at once; stall covers the first cycle of a new access.
  always_comb begin
    bus_req_valid = (state == REQ);
    stall         = ((state == IDLE) && op_ok) || (state == REQ) || (state == RSP);
  end

  // Access sequencing, request field capture, load data and sticky fault.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus_req_write <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      load_data     <= '0;
      fault         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_ok) begin
            bus_req_write <= mem_write;
            bus_req_addr  <= addr;
            bus_req_wdata <= wdata;
            state         <= REQ;
          end else if (op_bad) begin
            fault <= 1'b1;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            state <= RSP;
          end
        end
        RSP: begin
          if (bus_rsp_valid) begin
            if (!bus_req_write) begin
              load_data <= bus_rsp_rdata;
            end
            state <= DONE;
          end else if (timeout_hit) begin
            load_data <= '0;
            fault     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: directed and randomized
// loads/stores against a transaction-level expectation of stall length,
// request fields, load data and the sticky fault flag.
module tb_mem_access_controller;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall;
  logic [DATA_W-1:0] load_data;
  logic              fault;
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_write;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_load;
  logic              exp_fault;

  mem_access_controller #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .load_data    (load_data),
    .fault        (fault),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write),
    .bus_req_addr (bus_req_addr),
    .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_rdata(bus_rsp_rdata)
  );

  always #5 clock = ~clock;

  // Count one comparison and report it when observed differs from expected.
  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One aligned load or store with the given bus wait profile. Starts and
  // ends on a falling edge with the DUT idle.
  task automatic run_op(input bit is_write, input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_delay, input int rsp_delay, input logic [31:0] rd,
                        input bit no_rsp);
    int stall_cycles = 0;
    int req_wait = 0;
    int rsp_wait = 0;
    bit accepted = 0;
    bit responded = 0;
    bit finished = 0;
    bit stall_now;
    int exp_stall;
    logic [31:0] exp_after;
    bit exp_f;

    if (no_rsp) begin
      exp_after = '0;
      exp_f     = 1'b1;
      exp_stall = 2 + rdy_delay + TMO;
    end else begin
      exp_after = is_write ? exp_load : rd;
      exp_f     = exp_fault;
      exp_stall = 3 + rdy_delay + rsp_delay;
    end

    mem_read  = !is_write;
    mem_write = is_write;
    addr      = a;
    wdata     = wd;

    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      #1;
      stall_now = stall;
      if (cyc == 0) check_output("stall_first_cycle", stall, 1);
      if (bus_req_valid) begin
        check_output("req_write", bus_req_write, is_write);
        check_output("req_addr", bus_req_addr, a);
        check_output("req_wdata", bus_req_wdata, wd);
        bus_rsp_valid = 1'($urandom_range(0, 1));
        bus_rsp_rdata = $urandom;
        if (req_wait == rdy_delay) begin
          bus_req_ready = 1'b1;
          accepted      = 1'b1;
        end else begin
          req_wait++;
        end
      end else if (accepted && !responded && !no_rsp) begin
        if (rsp_wait == rsp_delay) begin
          bus_rsp_valid = 1'b1;
          bus_rsp_rdata = rd;
          responded     = 1'b1;
        end else begin
          rsp_wait++;
        end
      end
      if (stall_now) begin
        stall_cycles++;
      end else begin
        finished = 1'b1;
        check_output("done_after_access", accepted && (responded || no_rsp), 1);
        check_output("stall_cycles", stall_cycles, exp_stall);
        check_output("load_data", load_data, exp_after);
        check_output("fault", fault, exp_f);
      end
      @(negedge clock);
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
    end
    if (!finished) check_output("access_completed", 0, 1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    exp_load  = exp_after;
    exp_fault = exp_f;
  endtask

  // A misaligned or conflicting operation: no request, no stall, fault set.
  task automatic run_bad(input int kind, input logic [31:0] a);
    mem_read  = (kind != 1);
    mem_write = (kind != 0);
    addr      = a;
    wdata     = $urandom;
    #1;
    check_output("bad_stall", stall, 0);
    check_output("bad_req_valid", bus_req_valid, 0);
    @(negedge clock);
    #1;
    check_output("bad_fault", fault, 1);
    check_output("bad_no_req", bus_req_valid, 0);
    check_output("bad_load_kept", load_data, exp_load);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    exp_fault = 1'b1;
    @(negedge clock);
    #1;
    check_output("fault_sticky", fault, 1);
    @(negedge clock);
  endtask

  // Random aligned traffic with random bus wait states.
  task automatic apply_stimulus(input int count);
    for (int i = 0; i < count; i++) begin
      run_op(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
    end
  endtask

  initial begin
    reset         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    addr          = '0;
    wdata         = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    exp_load      = '0;
    exp_fault     = 1'b0;

    #2;
    check_output("rst_stall", stall, 0);
    check_output("rst_load_data", load_data, 0);
    check_output("rst_fault", fault, 0);
    check_output("rst_req_valid", bus_req_valid, 0);
    check_output("rst_req_write", bus_req_write, 0);
    check_output("rst_req_addr", bus_req_addr, 0);
    check_output("rst_req_wdata", bus_req_wdata, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op(1'b0, 32'h10, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    run_op(1'b1, 32'h20, 32'h1234_5678, 2, 0, 32'h5555_AAAA, 1'b0);
    apply_stimulus(20);

    run_bad(0, 32'h13);
    run_bad(1, ($urandom & 32'hFFFF_FFFC) | 32'h2);
    run_bad(2, 32'h40);
    run_op(1'b0, 32'h44, 32'h0, 1, 1, 32'hA5A5_0001, 1'b0);

    // Reset during RSP, then a late response that must be ignored.
    mem_read = 1'b1;
    addr     = 32'h80;
    @(negedge clock);
    #1;
    check_output("mid_req_valid", bus_req_valid, 1);
    bus_req_ready = 1'b1;
    @(negedge clock);
    bus_req_ready = 1'b0;
    mem_read      = 1'b0;
    #1;
    check_output("mid_rsp_stall", stall, 1);
    reset = 1'b0;
    #1;
    check_output("mid_rst_req_valid", bus_req_valid, 0);
    check_output("mid_rst_stall", stall, 0);
    check_output("mid_rst_load_data", load_data, 0);
    check_output("mid_rst_fault", fault, 0);
    @(negedge clock);
    reset         = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    bus_rsp_valid = 1'b0;
    #1;
    check_output("late_rsp_load_data", load_data, 0);
    check_output("late_rsp_stall", stall, 0);
    check_output("late_rsp_req_valid", bus_req_valid, 0);
    @(negedge clock);
    exp_load  = '0;
    exp_fault = 1'b0;

    apply_stimulus(6);

`ifdef MEM_TIMEOUT_EN
    run_op(1'b0, 32'h100, 32'h0, 1, 0, 32'h0, 1'b1);
    run_op(1'b0, 32'h104, 32'h0, 0, 2, 32'h0BAD_F00D, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
# mem_access_controller

Sequencer for the MEM stage of the 5-stage pipeline. Takes the memory-operation controls and operands held in the EX/MEM pipeline register and drives a variable-latency data-memory bus with a valid/ready request and a valid-only response. While an access is outstanding, it stalls the pipeline so the EX/MEM contents stay frozen. It returns load data to the MEM/WB path and flags misaligned, conflicting or timed-out accesses.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, response wait limit in cycles; used only with MEM_TIMEOUT_EN

Ports:
- clock  in  1  rising-edge clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  load request (MemRead_mem)
- mem_write  in  1  store request (MemWrite_mem)
- addr  in  ADDR_W  byte address (alu_result_mem)
- wdata  in  DATA_W  store data (read_data2_mem)
- stall  out  1  holds the PC, IF/ID, ID/EX and EX/MEM registers
- load_data  out  DATA_W  load result; valid in the DONE cycle
- fault  out  1  sticky error flag; cleared only by reset
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus request accepted
- bus_req_write  out  1  1 = store, 0 = load
- bus_req_addr  out  ADDR_W  request address
- bus_req_wdata  out  DATA_W  request store data
- bus_rsp_valid  in  1  response or write-acknowledge strobe
- bus_rsp_rdata  in  DATA_W  response data

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE, operation present:
  - Condition: exactly one of mem_read/mem_write is high and addr[1:0] == 0.
  - The block latches addr, wdata and write into request registers and moves to REQ.
- IDLE, misaligned operation:
  - Condition: mem_read or mem_write is high and addr[1:0] != 0.
  - fault is set, no bus request is issued, stall stays low and the state remains IDLE.
- IDLE, conflicting operation:
  - Condition: mem_read and mem_write are both high.
  - Handled the same as a misaligned operation.
- REQ:
  - bus_req_valid = 1. The request fields come from the latched registers and stay stable until accepted.
  - bus_req_valid is held until bus_req_ready = 1; the state then moves to RSP on the next edge.
- RSP:
  - Waits for bus_rsp_valid.
  - On a load, bus_rsp_rdata is captured into load_data.
  - On a store, bus_rsp_rdata is ignored and load_data keeps its previous value.
  - The state then moves to DONE.
- DONE:
  - stall = 0, so the pipeline advances at the end of this cycle.
  - The held EX/MEM operation is not restarted.
  - The state always returns to IDLE on the next edge.
- stall is combinational: high when (IDLE and a valid aligned operation is present) or the state is REQ or RSP; low otherwise.
- bus_rsp_valid outside RSP is ignored.
- All outputs other than stall and bus_req_valid are registered.

## Timing
- Reset values:
  - State: IDLE.
  - stall = 0, load_data = 0, fault = 0.
  - bus_req_valid = 0, bus_req_write = 0, bus_req_addr = 0, bus_req_wdata = 0.
- Cycle-level latency, with ready and response both zero-wait:
  - Cycle 0: operation appears; stall = 1.
  - Cycle 1: REQ with bus_req_valid = 1; ready is seen.
  - Cycle 2: RSP; rsp_valid is seen.
  - Cycle 3: DONE; load_data is valid and stall = 0.
- Minimum cost is 3 stall cycles per access. Each wait cycle on ready or on the response adds one cycle.
- The earliest accepted response is the cycle after request acceptance.
- Reset asserted mid-access: the FSM returns to IDLE and bus_req_valid drops immediately (asynchronous). A response that arrives later is ignored.
- Back-to-back operations: a new operation in EX/MEM during the cycle after DONE starts a new access from IDLE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles in RSP.
  - When the count reaches TIMEOUT_CYCLES with no response, the FSM moves to DONE, load_data is set to 0 and fault is set.
  - The counter clears on entry to RSP.
- MEM_TIMEOUT_EN undefined: RSP waits indefinitely and no counter logic is built.

## Structure
- Package mem_ctrl_pkg:
  - The state enum: IDLE, REQ, RSP, DONE.
  - A word-alignment mask constant.
  - The timeout width function.
- One sub-module, mem_timeout_counter: clear, enable and expired ports; instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Load: addr 0x10, ready and response zero-wait, rdata 0xDEADBEEF → stall high for 3 cycles; DONE cycle with load_data = 0xDEADBEEF; fault = 0.
- Store: addr 0x20, wdata 0x12345678, ready delayed 2 cycles → bus_req_addr and bus_req_wdata stable while valid is high; stall high for 5 cycles; load_data unchanged.
- Misaligned: load at 0x13 → no bus_req_valid, stall = 0, fault = 1 and stays 1 until reset.
- Conflict: mem_read = mem_write = 1 at 0x40 → no request, fault = 1.
- Reset mid-access: reset asserted during RSP, then a response arrives → state IDLE, bus_req_valid = 0, load_data = 0, response ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4: load with no response → DONE 4 cycles after entering RSP, load_data = 0, fault = 1.
